// File: rtl/gbfact_loader.sv
// Activation loader: splits a dense activation stream into packed nonzeros, a per-block
// MSB-first nonzero bitmap and, when GBFVNACT_EN is defined, a per-block nonzero count.
module gbfact_loader #(
    parameter int DATA_WIDTH   = 8,
    parameter int BLOCK_DEPTH  = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int NUMBLK_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           Cfg_Start,
    input  logic [NUMBLK_WIDTH-1:0]        Cfg_NumBlk,
    input  logic                           IN_Val,
    output logic                           IN_Rdy,
    input  logic [DATA_WIDTH-1:0]          IN_Dat,
    output logic                           GBFACT_EnWr,
    output logic [ADDR_WIDTH-1:0]          GBFACT_AddrWr,
    output logic [DATA_WIDTH-1:0]          GBFACT_DatWr,
    output logic                           GBFFLGACT_EnWr,
    output logic [ADDR_WIDTH-1:0]          GBFFLGACT_AddrWr,
    output logic [BLOCK_DEPTH-1:0]         GBFFLGACT_DatWr,
`ifdef GBFVNACT_EN
    output logic                           GBFVNACT_EnWr,
    output logic [ADDR_WIDTH-1:0]          GBFVNACT_AddrWr,
    output logic [$clog2(BLOCK_DEPTH)-1:0] GBFVNACT_DatWr,
`endif
    output logic                           GBFACT_Val,
    output logic                           GBFFLGACT_Val,
    output logic                           Busy,
    output logic                           Ovf
);

    localparam int CNT_W = $clog2(BLOCK_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

    state_t                   r_state, w_state_nxt;
    logic                     w_start, w_acc, w_nz, w_blk_end, w_last_blk;
    logic [NUMBLK_WIDTH-1:0]  r_numblk, r_blk_cnt;
    logic [CNT_W-1:0]         r_beat;
    logic [ADDR_WIDTH-1:0]    r_act_addr, r_flg_addr;
    logic [BLOCK_DEPTH-1:0]   r_flags, w_flags_nxt;
    logic                     r_ovf;
    logic                     r_act_en, r_flg_en;
    logic [ADDR_WIDTH-1:0]    r_act_addr_o, r_flg_addr_o;
    logic [DATA_WIDTH-1:0]    r_act_dat;
    logic [BLOCK_DEPTH-1:0]   r_flg_dat;
`ifdef GBFVNACT_EN
    logic [CNT_W-1:0]         r_cnt, w_cnt_nxt, r_vn_dat;
`endif

    assign w_acc       = IN_Val && (r_state == S_LOAD);
    assign w_nz        = (IN_Dat != '0);
    assign w_blk_end   = (r_beat == CNT_W'(BLOCK_DEPTH - 1));
    assign w_last_blk  = (r_blk_cnt == (r_numblk - 1'b1));
    // Shift-in keeps beat 0 in the MSB once the block is complete.
    assign w_flags_nxt = {r_flags[BLOCK_DEPTH-2:0], w_nz};
`ifdef GBFVNACT_EN
    assign w_cnt_nxt   = r_cnt + CNT_W'(w_nz);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_start     = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (Cfg_Start) begin
                    w_start     = 1'b1;
                    w_state_nxt = (Cfg_NumBlk == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD:  if (w_acc && w_blk_end && w_last_blk) w_state_nxt = S_FLUSH;
            S_FLUSH: w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_numblk     <= '0;
            r_blk_cnt    <= '0;
            r_beat       <= '0;
            r_act_addr   <= '0;
            r_flg_addr   <= '0;
            r_flags      <= '0;
            r_ovf        <= 1'b0;
            r_act_en     <= 1'b0;
            r_flg_en     <= 1'b0;
            r_act_addr_o <= '0;
            r_flg_addr_o <= '0;
            r_act_dat    <= '0;
            r_flg_dat    <= '0;
`ifdef GBFVNACT_EN
            r_cnt        <= '0;
            r_vn_dat     <= '0;
`endif
        end else begin
            r_act_en <= 1'b0;
            r_flg_en <= 1'b0;
            if (w_start) begin
                r_numblk   <= Cfg_NumBlk;
                r_blk_cnt  <= '0;
                r_beat     <= '0;
                r_act_addr <= '0;
                r_flg_addr <= '0;
                r_flags    <= '0;
                r_ovf      <= 1'b0;
`ifdef GBFVNACT_EN
                r_cnt      <= '0;
`endif
            end else if (w_acc) begin
                r_beat  <= r_beat + 1'b1;
                r_flags <= w_blk_end ? '0 : w_flags_nxt;
`ifdef GBFVNACT_EN
                r_cnt   <= w_blk_end ? '0 : w_cnt_nxt;
`endif
                if (w_nz) begin
                    r_act_en     <= 1'b1;
                    r_act_addr_o <= r_act_addr;
                    r_act_dat    <= IN_Dat;
                    r_act_addr   <= r_act_addr + 1'b1;
                    if (&r_act_addr) r_ovf <= 1'b1;
                end
                if (w_blk_end) begin
                    r_flg_en     <= 1'b1;
                    r_flg_addr_o <= r_flg_addr;
                    r_flg_dat    <= w_flags_nxt;
                    r_flg_addr   <= r_flg_addr + 1'b1;
                    r_blk_cnt    <= r_blk_cnt + 1'b1;
`ifdef GBFVNACT_EN
                    r_vn_dat     <= w_cnt_nxt;
`endif
                end
            end
        end
    end

    assign IN_Rdy           = (r_state == S_LOAD);
    assign Busy             = (r_state == S_LOAD) || (r_state == S_FLUSH);
    assign GBFACT_Val       = (r_state == S_DONE);
    assign GBFFLGACT_Val    = (r_state == S_DONE);
    assign Ovf              = r_ovf;
    assign GBFACT_EnWr      = r_act_en;
    assign GBFACT_AddrWr    = r_act_addr_o;
    assign GBFACT_DatWr     = r_act_dat;
    assign GBFFLGACT_EnWr   = r_flg_en;
    assign GBFFLGACT_AddrWr = r_flg_addr_o;
    assign GBFFLGACT_DatWr  = r_flg_dat;
`ifdef GBFVNACT_EN
    assign GBFVNACT_EnWr    = r_flg_en;
    assign GBFVNACT_AddrWr  = r_flg_addr_o;
    assign GBFVNACT_DatWr   = r_vn_dat;
`endif

endmodule

// File: tb/tb_gbfact_loader.sv
// Scoreboard bench for gbfact_loader: directed frames push expected buffer writes,
// a negedge monitor pops and compares them as the loader issues writes.
module tb_gbfact_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Cfg_Start;
    logic [15:0] Cfg_NumBlk;
    logic        IN_Val;
    logic        IN_Rdy;
    logic [7:0]  IN_Dat;
    logic        GBFACT_EnWr;
    logic [11:0] GBFACT_AddrWr;
    logic [7:0]  GBFACT_DatWr;
    logic        GBFFLGACT_EnWr;
    logic [11:0] GBFFLGACT_AddrWr;
    logic [31:0] GBFFLGACT_DatWr;
`ifdef GBFVNACT_EN
    logic        GBFVNACT_EnWr;
    logic [11:0] GBFVNACT_AddrWr;
    logic [4:0]  GBFVNACT_DatWr;
`endif
    logic        GBFACT_Val;
    logic        GBFFLGACT_Val;
    logic        Busy;
    logic        Ovf;

    always #5 clk = ~clk;

    gbfact_loader dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .Cfg_Start        (Cfg_Start),
        .Cfg_NumBlk       (Cfg_NumBlk),
        .IN_Val           (IN_Val),
        .IN_Rdy           (IN_Rdy),
        .IN_Dat           (IN_Dat),
        .GBFACT_EnWr      (GBFACT_EnWr),
        .GBFACT_AddrWr    (GBFACT_AddrWr),
        .GBFACT_DatWr     (GBFACT_DatWr),
        .GBFFLGACT_EnWr   (GBFFLGACT_EnWr),
        .GBFFLGACT_AddrWr (GBFFLGACT_AddrWr),
        .GBFFLGACT_DatWr  (GBFFLGACT_DatWr),
`ifdef GBFVNACT_EN
        .GBFVNACT_EnWr    (GBFVNACT_EnWr),
        .GBFVNACT_AddrWr  (GBFVNACT_AddrWr),
        .GBFVNACT_DatWr   (GBFVNACT_DatWr),
`endif
        .GBFACT_Val       (GBFACT_Val),
        .GBFFLGACT_Val    (GBFFLGACT_Val),
        .Busy             (Busy),
        .Ovf              (Ovf)
    );

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  dat;
        logic        ovf;
    } act_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] flg;
        logic [4:0]  cnt;
    } flg_t;

    act_t act_q[$];
    flg_t flg_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_act(input int addr, input logic [7:0] dat, input logic ovf);
        act_t e;
        e.addr = 12'(addr);
        e.dat  = dat;
        e.ovf  = ovf;
        act_q.push_back(e);
    endtask

    task automatic push_flg(input int addr, input logic [31:0] flg, input logic [4:0] cnt);
        flg_t e;
        e.addr = 12'(addr);
        e.flg  = flg;
        e.cnt  = cnt;
        flg_q.push_back(e);
    endtask

    // Monitor: every write the loader issues must match the oldest expectation.
    always @(negedge clk) begin
        if (GBFACT_EnWr) begin
            if (act_q.size() == 0) begin
                check("act_unexpected", {GBFACT_AddrWr, GBFACT_DatWr}, 64'hDEAD);
            end else begin
                act_t e;
                e = act_q.pop_front();
                check("act_wr", {GBFACT_AddrWr, GBFACT_DatWr, Ovf}, {e.addr, e.dat, e.ovf});
            end
        end
        if (GBFFLGACT_EnWr) begin
            if (flg_q.size() == 0) begin
                check("flg_unexpected", {GBFFLGACT_AddrWr, GBFFLGACT_DatWr}, 64'hDEAD);
            end else begin
                flg_t f;
                f = flg_q.pop_front();
                check("flg_wr", {GBFFLGACT_AddrWr, GBFFLGACT_DatWr}, {f.addr, f.flg});
`ifdef GBFVNACT_EN
                check("vn_wr", {GBFVNACT_EnWr, GBFVNACT_AddrWr, GBFVNACT_DatWr}, {1'b1, f.addr, f.cnt});
`endif
            end
        end
    end

    task automatic start(input logic [15:0] nb);
        Cfg_Start  = 1'b1;
        Cfg_NumBlk = nb;
        @(negedge clk);
        Cfg_Start  = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d);
        IN_Val = 1'b1;
        IN_Dat = d;
        @(negedge clk);
    endtask

    task automatic idle();
        IN_Val = 1'b0;
        IN_Dat = 8'h00;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, {IN_Rdy, GBFACT_EnWr, GBFFLGACT_EnWr, GBFACT_Val, GBFFLGACT_Val, Busy, Ovf}, 64'h0);
        check({name, "_data"}, {63'h0, |{GBFACT_AddrWr, GBFACT_DatWr, GBFFLGACT_AddrWr, GBFFLGACT_DatWr}}, 64'h0);
    endtask

    initial begin
        logic [7:0] d;
        rst_n = 1'b0; Cfg_Start = 1'b0; Cfg_NumBlk = '0; IN_Val = 1'b0; IN_Dat = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Empty frame: done one cycle after start, never busy
        check("nb0_val_before", {GBFACT_Val, GBFFLGACT_Val}, 64'h0);
        start(16'd0);
        check("nb0_done", {Busy, IN_Rdy, GBFACT_Val, GBFFLGACT_Val, GBFACT_EnWr, GBFFLGACT_EnWr}, 64'b001100);
        idle();

        // One block of 0x01..0x20; a mid-frame start pulse must be ignored
        start(16'd1);
        check("t1_load", {Busy, IN_Rdy, GBFACT_Val}, 64'b110);
        for (int i = 0; i < 32; i++) begin
            push_act(i, 8'(i + 1), 1'b0);
            if (i == 31) push_flg(0, 32'hFFFF_FFFF, 5'd0);
            if (i == 5) begin Cfg_Start = 1'b1; Cfg_NumBlk = 16'd0; end
            beat(8'(i + 1));
            Cfg_Start = 1'b0;
        end
        check("t1_flush", {Busy, IN_Rdy, GBFACT_Val, GBFFLGACT_Val}, 64'b1000);
        idle();
        check("t1_done", {Busy, IN_Rdy, GBFACT_Val, GBFFLGACT_Val, Ovf}, 64'b00110);

        // Two blocks: all zero, then 0x05 at beat 0 and 0x07 at beat 31
        start(16'd2);
        check("t2_val_cleared", {GBFACT_Val, GBFFLGACT_Val}, 64'h0);
        for (int i = 0; i < 32; i++) begin
            if (i == 31) push_flg(0, 32'h0000_0000, 5'd0);
            beat(8'h00);
        end
        push_act(0, 8'h05, 1'b0);
        beat(8'h05);
        for (int i = 1; i < 31; i++) beat(8'h00);
        push_act(1, 8'h07, 1'b0);
        push_flg(1, 32'h8000_0001, 5'd2);
        beat(8'h07);
        idle();
        check("t2_done", {GBFACT_Val, GBFFLGACT_Val}, 64'b11);

        // IN_Val gaps at the block boundary and mid-block
        start(16'd2);
        for (int i = 0; i < 32; i++) begin
            d = (i % 4 == 0) ? 8'(i + 1) : 8'h00;
            if (d != 8'h00) push_act(i / 4, d, 1'b0);
            if (i == 31) push_flg(0, 32'h8888_8888, 5'd8);
            beat(d);
        end
        check("t3_flg_after_b31", {GBFFLGACT_EnWr}, 64'h1);
        idle();
        check("t3_gap_no_wr", {GBFACT_EnWr, GBFFLGACT_EnWr, IN_Rdy}, 64'b001);
        for (int i = 0; i < 32; i++) begin
            if (i == 16) idle();
            push_act(8 + i, 8'hFF, 1'b0);
            if (i == 31) push_flg(1, 32'hFFFF_FFFF, 5'd0);
            beat(8'hFF);
        end
        idle();
        check("t3_done", {GBFACT_Val, Busy}, 64'b10);

        // Reset mid-block at beat 10, then a fresh frame from address 0
        start(16'd1);
        for (int i = 0; i < 10; i++) begin
            push_act(i, 8'(i + 1), 1'b0);
            beat(8'(i + 1));
        end
        rst_n = 1'b0; IN_Val = 1'b1; IN_Dat = 8'h0B;
        @(negedge clk);
        rst_n = 1'b1; IN_Val = 1'b0; IN_Dat = 8'h00;
        check_all_zero("midrst");
        idle();
        start(16'd1);
        for (int i = 0; i < 32; i++) begin
            d = (i % 2 == 0) ? 8'(8'h40 + i) : 8'h00;
            if (d != 8'h00) push_act(i / 2, d, 1'b0);
            if (i == 31) push_flg(0, 32'hAAAA_AAAA, 5'd16);
            beat(d);
        end
        idle();
        check("t5_done", {GBFACT_Val, Ovf}, 64'b10);

        // 129 dense blocks: GBFACT address wraps after 4096 writes and Ovf sticks
        start(16'd129);
        for (int n = 0; n < 129 * 32; n++) begin
            d = 8'((n % 200) + 1);
            push_act(n % 4096, d, (n >= 4095) ? 1'b1 : 1'b0);
            if (n % 32 == 31) push_flg(n / 32, 32'hFFFF_FFFF, 5'd0);
            beat(d);
        end
        idle();
        check("wrap_done", {GBFACT_Val, Ovf}, 64'b11);
        start(16'd0);
        check("ovf_cleared", {GBFACT_Val, Ovf}, 64'b10);
        idle();

        check("act_q_empty", 64'(act_q.size()), 64'h0);
        check("flg_q_empty", 64'(flg_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gbfact_loader.md
# gbfact_loader

Activation loader that sits directly upstream of the TS3D activation global buffers. It accepts a dense stream of activations, one per beat, and splits each BLOCK_DEPTH-long block into three outputs: the packed nonzero values, written to GBFACT; a nonzero-flag bitmap, written to GBFFLGACT; and, optionally, a per-block nonzero count, written to GBFVNACT. Its write ports connect one-to-one with the TS3D GBFACT/GBFFLGACT/GBFVNACT write ports.

## Interface
Parameters:
- DATA_WIDTH, 8, activation width
- BLOCK_DEPTH, 32, activations per block (power of two, ≥4)
- ADDR_WIDTH, 12, GBFACT/GBFFLGACT/GBFVNACT address width
- NUMBLK_WIDTH, 16, width of block-count config

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- Cfg_Start  in  1  one-cycle pulse; starts a frame
- Cfg_NumBlk  in  NUMBLK_WIDTH  blocks in frame, sampled on Cfg_Start
- IN_Val  in  1  activation valid
- IN_Rdy  out  1  loader accepts activation
- IN_Dat  in  DATA_WIDTH  activation
- GBFACT_EnWr / GBFACT_AddrWr / GBFACT_DatWr  out  1 / ADDR_WIDTH / DATA_WIDTH  packed nonzero write
- GBFFLGACT_EnWr / GBFFLGACT_AddrWr / GBFFLGACT_DatWr  out  1 / ADDR_WIDTH / BLOCK_DEPTH  flag write
- GBFVNACT_EnWr / GBFVNACT_AddrWr / GBFVNACT_DatWr  out  1 / ADDR_WIDTH / log2(BLOCK_DEPTH)  count write (GBFVNACT_EN only)
- GBFACT_Val, GBFFLGACT_Val  out  1  frame fully written; buffers valid
- Busy  out  1  state is LOAD or FLUSH
- Ovf  out  1  sticky; GBFACT address wrapped during the frame

## Operation
- States: IDLE → LOAD → FLUSH → DONE.
  - IDLE/DONE + Cfg_Start: clear the address counters, beat counter, block counter, Ovf, and both _Val outputs; latch Cfg_NumBlk. Go to LOAD, or to DONE if Cfg_NumBlk = 0.
  - LOAD: IN_Rdy = 1. A beat is accepted when IN_Val & IN_Rdy. When the final beat of the final block is accepted, go to FLUSH.
  - FLUSH: IN_Rdy = 0. Go to DONE after one cycle, during which the last writes issue.
  - DONE: _Val outputs high until the next Cfg_Start or reset.
- Cfg_Start is ignored in LOAD and FLUSH.
- Per accepted beat k (k = 0..BLOCK_DEPTH-1 within the block):
  - If IN_Dat ≠ 0: write IN_Dat to GBFACT at act_addr, then increment act_addr.
  - Flag bit [BLOCK_DEPTH-1-k] = (IN_Dat ≠ 0), MSB-first.
- At beat BLOCK_DEPTH-1: write the completed flag word at flg_addr, then increment flg_addr and the block counter. Clear the flag accumulator for the next block.
- Address counters are modulo 2^ADDR_WIDTH. When act_addr wraps from all-ones to 0, Ovf sets and stays set.
- The write ports never stall; a downstream buffer must accept a write every cycle.
- Reset mid-frame: return to IDLE. All outputs go to 0 and partial block data is discarded.

## Timing
- Reset values: all outputs 0. IN_Rdy = 0 in IDLE.
- A beat accepted at cycle t drives GBFACT_EnWr/Addr/Dat at t+1 (registered).
- The flag write for a block whose last beat is accepted at t issues at t+1, concurrently with that beat's value write.
- The next block's first beat can be accepted at t+1. There is no bubble between blocks.
- Final beat at t: the writes issue at t+1 (FLUSH), and _Val rises at t+2 (DONE).
- Cfg_NumBlk = 0: _Val rises 1 cycle after Cfg_Start.
- Throughput: 1 activation per cycle.

## Configuration
- GBFVNACT_EN defined:
  - The loader maintains a per-block nonzero count.
  - At the flag write it writes GBFVNACT_DatWr = count mod BLOCK_DEPTH, with GBFVNACT_AddrWr = flg_addr and the same timing.
  - An all-nonzero block encodes 0 and is disambiguated by its all-ones flag word.
- GBFVNACT_EN undefined: the GBFVNACT ports and the counter are absent.

## Test plan
- Reset, then Cfg_Start with NumBlk=1, then 32 beats of 0x01..0x20 → 32 GBFACT writes at addrs 0..31; flag 0xFFFFFFFF at addr 0; VNACT 0; _Val high 2 cycles after the last beat.
- NumBlk=2, block 0 all zero, block 1 = 0x05 at beat 0 and 0x07 at beat 31 → no GBFACT writes for block 0; flag 0x00000000 at addr 0; GBFACT 0x05@0, 0x07@1; flag 0x80000001 at addr 1; VNACT 2 at addr 1.
- IN_Val toggled 1-0-1 across a block boundary → writes only on accepted beats; the flag write issues the cycle after beat 31 regardless of the gap.
- Cfg_NumBlk=0 → _Val rises 1 cycle after Cfg_Start; no writes; Busy never asserts.
- ADDR_WIDTH=4, 1 block of 32 nonzero values → GBFACT addrs 0..15 then 0..15 again; Ovf set after the 16th write.
- rst_n low for 1 cycle at beat 10 → all outputs 0 next cycle; a fresh Cfg_Start restarts from addr 0.
